voice_allocator: RTL and testbench

Polyphonic voice allocator for the synth's wave generators. It accepts note-on/note-off events through a valid/ready handshake and assigns each note to one of `NUM_VOICES` voice slots. When every slot is busy, it steals the oldest voice. For each slot it drives the generator's period, an active flag and a one-cycle retrigger pulse, and it sits between the note-event source and the bank of triangle/other wave generators.

---
 rtl/voice_allocator.sv | 272 +++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto NUM_VOICES slots,
// stealing the oldest slot when all are busy. One event per three cycles.

// One voice slot: holds key/period/stamp and reports key match and age.
module voice_slot #(
    parameter int KEY_W    = 7,
    parameter int PERIOD_W = 32,
    parameter int STAMP_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic                clr_en,
    input  logic [KEY_W-1:0]    wr_key,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [STAMP_W-1:0]  wr_stamp,
    input  logic [KEY_W-1:0]    cmp_key,
    input  logic [STAMP_W-1:0]  cur_cnt,
    output logic                active,
    output logic [PERIOD_W-1:0] period,
    output logic                retrig,
    output logic                match,
    output logic [STAMP_W-1:0]  age
);
    logic                active_q, active_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [STAMP_W-1:0]  stamp_q, stamp_d;
    logic                retrig_q, retrig_d;

    // Next slot contents: allocation overrides release; retrig mirrors allocation.
    always_comb begin
        active_d = active_q;
        key_d    = key_q;
        period_d = period_q;
        stamp_d  = stamp_q;
        retrig_d = set_en;
        if (set_en) begin
            active_d = 1'b1;
            key_d    = wr_key;
            period_d = wr_period;
            stamp_d  = wr_stamp;
        end else if (clr_en) begin
            active_d = 1'b0;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            key_q    <= '0;
            period_q <= '0;
            stamp_q  <= '0;
            retrig_q <= 1'b0;
        end else begin
            active_q <= active_d;
            key_q    <= key_d;
            period_q <= period_d;
            stamp_q  <= stamp_d;
            retrig_q <= retrig_d;
        end
    end

    assign active = active_q;
    assign period = period_q;
    assign retrig = retrig_q;
    // Only sounding slots may match, so a released key never retriggers in place.
    assign match  = active_q && (key_q == cmp_key);
    // Modular age stays correct across alloc_cnt wrap.
    assign age    = cur_cnt - stamp_q;
endmodule

// Allocator top: event FSM, lookup registers and the slot array.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 7,
    parameter int PERIOD_W   = 32,
    parameter int STAMP_W    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ev_valid,
    output logic                           ev_ready,
    input  logic                           ev_note_on,
    input  logic [KEY_W-1:0]               ev_key,
    input  logic [PERIOD_W-1:0]            ev_period,
    output logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic [NUM_VOICES-1:0]          voice_retrig,
    output logic                           steal,
    output logic                           ev_err
);
    localparam int IDX_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_APPLY} state_t;

    typedef struct packed {
        logic                note_on;
        logic [KEY_W-1:0]    key;
        logic [PERIOD_W-1:0] period;
    } ev_t;

    state_t state_q, state_d;

    ev_t                   ev_q, ev_d;
    logic [NUM_VOICES-1:0] match_vec_q, match_vec_d;
    logic                  free_any_q, free_any_d;
    logic [IDX_W-1:0]      free_idx_q, free_idx_d;
    logic [IDX_W-1:0]      old_idx_q, old_idx_d;
    logic [STAMP_W-1:0]    alloc_cnt_q, alloc_cnt_d;
    logic                  steal_q, steal_d;
    logic                  err_q, err_d;

    logic [IDX_W-1:0]      hit_idx;
    logic [IDX_W-1:0]      target;
    logic [STAMP_W-1:0]    best_age;

    logic [NUM_VOICES-1:0]               slot_active;
    logic [NUM_VOICES-1:0]               slot_match;
    logic [NUM_VOICES-1:0]               slot_retrig;
    logic [NUM_VOICES-1:0]               slot_set;
    logic [NUM_VOICES-1:0]               slot_clr;
    logic [NUM_VOICES-1:0][PERIOD_W-1:0] slot_period;
    logic [NUM_VOICES-1:0][STAMP_W-1:0]  slot_age;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: accept, look up, apply, back to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ev_valid) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_APPLY;
            S_APPLY:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: only idle accepts events.
    always_comb begin
        ev_ready = (state_q == S_IDLE);
    end

    // Index of the (at most one) matching slot seen during lookup.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            if (match_vec_q[i]) hit_idx = IDX_W'(i);
    end

    // Datapath: latch event, register lookup results, then update one slot.
    always_comb begin
        ev_d        = ev_q;
        match_vec_d = match_vec_q;
        free_any_d  = free_any_q;
        free_idx_d  = free_idx_q;
        old_idx_d   = old_idx_q;
        alloc_cnt_d = alloc_cnt_q;
        steal_d     = 1'b0;
        err_d       = 1'b0;
        slot_set    = '0;
        slot_clr    = '0;
        target      = '0;
        best_age    = '0;
        case (state_q)
            S_IDLE: begin
                if (ev_valid) begin
                    ev_d.note_on = ev_note_on;
                    ev_d.key     = ev_key;
                    ev_d.period  = ev_period;
                end
            end
            S_LOOKUP: begin
                match_vec_d = slot_match;
                // Descending scan so the lowest free index wins.
                free_any_d = 1'b0;
                free_idx_d = '0;
                for (int i = NUM_VOICES - 1; i >= 0; i--) begin
                    if (!slot_active[i]) begin
                        free_any_d = 1'b1;
                        free_idx_d = IDX_W'(i);
                    end
                end
                // Strict compare keeps the lowest index on equal ages.
                old_idx_d = '0;
                best_age  = slot_age[0];
                for (int i = 1; i < NUM_VOICES; i++) begin
                    if (slot_age[i] > best_age) begin
                        best_age  = slot_age[i];
                        old_idx_d = IDX_W'(i);
                    end
                end
            end
            S_APPLY: begin
                if (ev_q.note_on) begin
                    if (ev_q.period == '0) begin
                        err_d = 1'b1;
                    end else begin
                        if (|match_vec_q)    target = hit_idx;
                        else if (free_any_q) target = free_idx_q;
                        else begin
                            target  = old_idx_q;
                            steal_d = 1'b1;
                        end
                        slot_set[target] = 1'b1;
                        alloc_cnt_d      = alloc_cnt_q + 1'b1;
                    end
                end else begin
                    slot_clr = match_vec_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_q        <= '0;
            match_vec_q <= '0;
            free_any_q  <= 1'b0;
            free_idx_q  <= '0;
            old_idx_q   <= '0;
            alloc_cnt_q <= '0;
            steal_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ev_q        <= ev_d;
            match_vec_q <= match_vec_d;
            free_any_q  <= free_any_d;
            free_idx_q  <= free_idx_d;
            old_idx_q   <= old_idx_d;
            alloc_cnt_q <= alloc_cnt_d;
            steal_q     <= steal_d;
            err_q       <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
        voice_slot #(
            .KEY_W    (KEY_W),
            .PERIOD_W (PERIOD_W),
            .STAMP_W  (STAMP_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .set_en    (slot_set[g]),
            .clr_en    (slot_clr[g]),
            .wr_key    (ev_q.key),
            .wr_period (ev_q.period),
            .wr_stamp  (alloc_cnt_q),
            .cmp_key   (ev_q.key),
            .cur_cnt   (alloc_cnt_q),
            .active    (slot_active[g]),
            .period    (slot_period[g]),
            .retrig    (slot_retrig[g]),
            .match     (slot_match[g]),
            .age       (slot_age[g])
        );
    end

    assign voice_period = slot_period;
    assign voice_active = slot_active;
    assign voice_retrig = slot_retrig;
    assign steal        = steal_q;
    assign ev_err       = err_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed steps plus random events against a
// slot-table model built from the allocation rules.
module tb_voice_allocator;
    localparam int NV = 4;
    localparam int KW = 7;
    localparam int PW = 32;
    localparam int SW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_note_on;
    logic [KW-1:0]     ev_key;
    logic [PW-1:0]     ev_period;
    logic [NV*PW-1:0]  voice_period;
    logic [NV-1:0]     voice_active;
    logic [NV-1:0]     voice_retrig;
    logic              steal;
    logic              ev_err;

    int errors = 0;
    int checks = 0;

    // Reference slot table.
    bit          m_active [NV];
    int          m_key    [NV];
    logic [31:0] m_period [NV];
    int          m_stamp  [NV];
    int          m_cnt;
    logic [NV-1:0] e_retrig;
    logic          e_steal;
    logic          e_err;

    voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .PERIOD_W(PW), .STAMP_W(SW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_note_on   (ev_note_on),
        .ev_key       (ev_key),
        .ev_period    (ev_period),
        .voice_period (voice_period),
        .voice_active (voice_active),
        .voice_retrig (voice_retrig),
        .steal        (steal),
        .ev_err       (ev_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 0; m_key[i] = 0; m_period[i] = 0; m_stamp[i] = 0;
        end
        m_cnt = 0;
    endtask

    // Applies one event to the table and sets the expected pulses.
    task automatic model_event(input bit on, input int key, input logic [31:0] per);
        int tgt, best;
        e_retrig = '0; e_steal = 0; e_err = 0;
        tgt = -1;
        for (int i = 0; i < NV; i++)
            if (m_active[i] && m_key[i] == key) tgt = i;
        if (!on) begin
            if (tgt >= 0) m_active[tgt] = 0;
        end else if (per == 0) begin
            e_err = 1;
        end else begin
            if (tgt < 0)
                for (int i = NV - 1; i >= 0; i--)
                    if (!m_active[i]) tgt = i;
            if (tgt < 0) begin
                best = -1;
                for (int i = 0; i < NV; i++)
                    if (((m_cnt - m_stamp[i]) % 65536 + 65536) % 65536 > best) begin
                        best = ((m_cnt - m_stamp[i]) % 65536 + 65536) % 65536;
                        tgt  = i;
                    end
                e_steal = 1;
            end
            m_active[tgt] = 1; m_key[tgt] = key; m_period[tgt] = per;
            m_stamp[tgt] = m_cnt; m_cnt = (m_cnt + 1) % 65536;
            e_retrig[tgt] = 1'b1;
        end
    endtask

    function automatic logic [127:0] exp_active();
        logic [127:0] v = '0;
        for (int i = 0; i < NV; i++) v[i] = m_active[i];
        return v;
    endfunction

    function automatic logic [127:0] exp_period();
        logic [127:0] v = '0;
        for (int i = 0; i < NV; i++) v[i*32 +: 32] = m_period[i];
        return v;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".active"}, 128'(voice_active), exp_active());
        chk({tag, ".period"}, 128'(voice_period), exp_period());
    endtask

    // Drive one event through the handshake and check every cycle of it.
    task automatic send(input bit on, input int key, input logic [31:0] per, input string tag);
        int n = 0;
        @(negedge clk);
        while (!ev_ready && n < 20) begin @(negedge clk); n++; end
        chk({tag, ".ready_wait"}, 128'(ev_ready), 128'(1));
        ev_valid = 1'b1; ev_note_on = on; ev_key = KW'(key); ev_period = per;
        @(posedge clk); #1;
        // Junk on the inputs while busy must be ignored.
        ev_valid = 1'b0; ev_note_on = 1'($urandom); ev_key = KW'($urandom); ev_period = $urandom;
        model_event(on, key, per);
        @(negedge clk);
        chk({tag, ".busy1"}, 128'(ev_ready), 128'(0));
        chk({tag, ".early_retrig"}, 128'(voice_retrig), 128'(0));
        @(negedge clk);
        chk({tag, ".busy2"}, 128'(ev_ready), 128'(0));
        @(negedge clk);
        chk({tag, ".ready_back"}, 128'(ev_ready), 128'(1));
        chk({tag, ".retrig"}, 128'(voice_retrig), 128'(e_retrig));
        chk({tag, ".steal"}, 128'(steal), 128'(e_steal));
        chk({tag, ".err"}, 128'(ev_err), 128'(e_err));
        check_state(tag);
        @(negedge clk);
        chk({tag, ".pulse_clear"}, {125'(0), voice_retrig != 0, steal, ev_err}, 128'(0));
    endtask

    initial begin
        int k;
        logic [31:0] p;
        bit on;
        reset = 1'b1; ev_valid = 1'b0; ev_note_on = 1'b0; ev_key = '0; ev_period = '0;
        model_reset();
        #12;
        chk("rst.ready", 128'(ev_ready), 128'(1));
        chk("rst.pulses", {125'(0), voice_retrig != 0, steal, ev_err}, 128'(0));
        check_state("rst");
        @(negedge clk); reset = 1'b0;

        // Fill all four slots in order.
        send(1, 60, 1000, "fill60");
        send(1, 61, 1100, "fill61");
        send(1, 62, 1200, "fill62");
        send(1, 63, 1300, "fill63");
        chk("full.active", 128'(voice_active), 128'(4'b1111));
        // Steal the oldest slot.
        send(1, 64, 900, "steal64");
        chk("steal.slot0", 128'(voice_period[31:0]), 128'(900));
        // Retrigger an already sounding key.
        send(1, 61, 1111, "retrig61");
        chk("retrig.slot1", 128'(voice_period[63:32]), 128'(1111));
        // Release, reuse and unknown release.
        send(0, 62, 0, "off62");
        chk("off.period_kept", 128'(voice_period[95:64]), 128'(1200));
        send(1, 70, 500, "reuse70");
        send(0, 99, 0, "off99");
        // Zero period is rejected.
        send(1, 5, 0, "zero_per");
        send(1, 71, 321, "after_err");

        // Random traffic on a small key range to exercise matches and steals.
        for (int i = 0; i < 250; i++) begin
            k  = $urandom_range(0, 9);
            on = ($urandom_range(0, 9) < 7);
            p  = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            send(on, k, p, "rand");
        end

        // Reset while a note-on sits in lookup.
        @(negedge clk);
        ev_valid = 1'b1; ev_note_on = 1'b1; ev_key = 7'd50; ev_period = 32'd777;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst.ready", 128'(ev_ready), 128'(1));
        chk("midrst.pulses", {125'(0), voice_retrig != 0, steal, ev_err}, 128'(0));
        check_state("midrst");
        @(negedge clk); reset = 1'b0;
        send(1, 80, 4242, "post_rst");
        chk("post_rst.slot0", 128'(voice_active), 128'(4'b0001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if the sequence wedges somewhere unexpected.
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
